sr_2_pipe: RTL and testbench
============================

Name: sr_2_pipe

Overview:
- Inverse of the team's shift-left-by-2 datapath block: pipelined signed divide-by-4.
- Arithmetic right shift by 2 with selectable rounding, remainder output, and saturation/overflow on narrowing to RES_WIDTH.
- Two-stage pipeline with valid/ready handshake on both sides; one result per cycle.
- Sits downstream of scaled-up (×4) arithmetic to return values to original scale.

Parameters:
- ARG_WIDTH, 32, width of signed input a (>= 3).
- RES_WIDTH, ARG_WIDTH, width of signed quotient res (>= 2).
- ROUND_MODE, RM_FLOOR, rounding of quotient: RM_FLOOR (arithmetic shift, toward -inf) or RM_TRUNC (toward zero, C-style a/4).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- arg_vld  input  1  input operand valid.
- arg_rdy  output  1  block accepts operand this cycle.
- a  input  ARG_WIDTH  signed dividend.
- res_vld  output  1  result valid.
- res_rdy  input  1  downstream accepts result.
- res  output  RES_WIDTH  signed quotient, saturated.
- rem  output  3  signed remainder; a == 4*q_exact + rem.
- overflow  output  1  q_exact did not fit RES_WIDTH; res saturated. Qualified by res_vld.

Behaviour:
- Reset (rst=1 at clock edge): s1_vld, s2_vld, res_vld, overflow = 0; res, rem, all data registers = 0; arg_rdy = 0 while rst is high.
- Transfer: input on arg_vld && arg_rdy; output on res_vld && res_rdy. Hold res/rem/overflow stable while res_vld && !res_rdy.
- Pipeline: S1 registers q_exact (ARG_WIDTH-1 bits) and rem; S2 registers saturated res and overflow. Stage advances when its output register is empty or its consumer takes data.
  - en2 = !s2_vld || res_rdy
  - en1 = !s1_vld || en2
  - arg_rdy = en1 && !rst
- Latency: 2 cycles from accept to res_vld with res_rdy held high. Full throughput; no bubbles under continuous flow.
- Backpressure: with res_rdy=0, holds exactly 2 items, then arg_rdy=0. No item dropped or duplicated.
- Arithmetic, RM_FLOOR: q_exact = a >>> 2; rem = {1'b0, a[1:0]}, range 0..3.
- Arithmetic, RM_TRUNC: q_exact = (a + (a<0 ? 3 : 0)) >>> 2; rem = a - 4*q_exact, range -3..3, sign of a (0 if exact).
- Adder for RM_TRUNC is ARG_WIDTH+1 bits; no internal overflow at a = min.
- Narrowing, RES_WIDTH >= ARG_WIDTH-1: sign-extend; overflow constant 0.
- Narrowing, RES_WIDTH < ARG_WIDTH-1:
  - q_exact > 2^(RES_WIDTH-1)-1: res = max, overflow = 1.
  - q_exact < -2^(RES_WIDTH-1): res = min, overflow = 1.
  - Otherwise truncate, overflow = 0.
  - rem is always exact, even when saturated.
- Boundaries:
  - a = -2^(ARG_WIDTH-1) gives exact quotient, no overflow when widths allow.
  - Simultaneous accept and emit in the same cycle is legal and keeps the pipeline full.
  - rst mid-operation flushes both stages; in-flight items are lost, no res_vld on the following cycle.
  - arg_vld during rst is ignored.

Decomposition:
- Package sr_pkg:
  - typedef enum round_mode_e {RM_FLOOR, RM_TRUNC}
  - localparam REM_WIDTH = 3
  - function sat_narrow (generic-width saturation helper)
- Sub-module pipe_slice: one valid/ready register stage (parameter WIDTH; ports clk, rst, in_vld, in_rdy, in_data, out_vld, out_rdy, out_data).
- Instantiated twice; S1 and S2 combinational logic stays in sr_2_pipe.

Test Plan:
- ARG_WIDTH=8, RES_WIDTH=8, RM_FLOOR, res_rdy=1: a = 13, -13, -128 on consecutive cycles -> (res, rem) = (3, 1), (-4, 3), (-32, 0) on cycles 2, 3, 4; overflow = 0.
- Same widths, RM_TRUNC: a = -13, -12, 13 -> (-3, -1), (-3, 0), (3, 1).
- RES_WIDTH=4, RM_FLOOR: a = 40, -40, -33, 28 -> (7, ov=1), (-8, ov=1), (-8, ov=1, rem=3), (7, ov=0). RM_TRUNC: a = -33 -> (-8, rem=-1, ov=0).
- Backpressure: stream a = 4, 8, 12, 16, with res_rdy=0 from cycle 1.
  - arg_rdy drops after 2 accepts.
  - Release res_rdy: outputs 1, 2, 3, 4 in order, none lost.
  - res stable while stalled.
- Reset mid-flight: two items in pipe, assert rst one cycle -> res_vld = 0, res = 0, arg_rdy = 0 during rst. Next input yields a correct result 2 cycles after accept.
- Random: 10k random a, random res_rdy/arg_vld in both modes. Scoreboard checks 4*q_exact + rem == a, saturation rule, and in-order delivery.

Source files
------------

// File: rtl/sr_2_pipe_pkg.sv
// Shared types and helpers for the sr_2_pipe signed divide-by-4 pipeline.
// sat_narrow clamps a sign-extended 64-bit value into a w-bit signed range.
package sr_pkg;

    typedef enum logic {RM_FLOOR, RM_TRUNC} round_mode_e;

    localparam int REM_WIDTH = 3;
    localparam int SAT_WIDTH = 64;

    function automatic logic signed [SAT_WIDTH-1:0] sat_narrow(
        input  logic signed [SAT_WIDTH-1:0] v,
        input  int                          w,
        output logic                        ovf
    );
        logic signed [SAT_WIDTH-1:0] max_v;
        logic signed [SAT_WIDTH-1:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        ovf   = 1'b0;
        if (v > max_v) begin
            ovf = 1'b1;
            return max_v;
        end
        if (v < min_v) begin
            ovf = 1'b1;
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/sr_2_pipe_slice.sv
// One valid/ready register stage; data moves only on a completed transfer.
module pipe_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);

    // Handshake: a transfer happens on a rising edge where vld && rdy; a producer
    // holds vld and data until it is taken, and rdy never depends on vld.
    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/sr_2_pipe.sv
// Pipelined signed divide-by-4: S1 forms the exact quotient and remainder,
// S2 narrows the quotient to RES_WIDTH with saturation.
module sr_2_pipe
    import sr_pkg::*;
#(
    parameter int          ARG_WIDTH  = 32,
    parameter int          RES_WIDTH  = ARG_WIDTH,
    parameter round_mode_e ROUND_MODE = RM_FLOOR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [ARG_WIDTH-1:0] a,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [RES_WIDTH-1:0] res,
    output logic [REM_WIDTH-1:0] rem,
    output logic                 overflow
);

    localparam int Q_WIDTH  = ARG_WIDTH - 1;
    localparam int S1_WIDTH = Q_WIDTH + REM_WIDTH;
    localparam int S2_WIDTH = RES_WIDTH + 1 + REM_WIDTH;

    logic signed [Q_WIDTH-1:0]   q_exact;
    logic        [REM_WIDTH-1:0] rem_exact;
    logic                        s1_in_rdy;
    logic                        s1_vld;
    logic        [S1_WIDTH-1:0]  s1_data;
    logic signed [Q_WIDTH-1:0]   s1_q;
    logic        [REM_WIDTH-1:0] s1_rem;
    logic                        s2_in_rdy;
    logic        [RES_WIDTH-1:0] res_next;
    logic                        ovf_next;
    logic        [S2_WIDTH-1:0]  s2_data;

    generate
        if (ROUND_MODE == RM_TRUNC) begin : g_trunc
            // Bias negatives by 3 so the floor shift rounds toward zero; one
            // extra bit keeps a = min from wrapping.
            localparam logic [ARG_WIDTH:0] BIAS = (ARG_WIDTH + 1)'(3);
            logic signed [ARG_WIDTH:0] biased;
            always_comb begin
                biased    = {a[ARG_WIDTH-1], a} + (a[ARG_WIDTH-1] ? BIAS : '0);
                q_exact   = biased[ARG_WIDTH:2];
                rem_exact = {1'b0, biased[1:0]} - (a[ARG_WIDTH-1] ? 3'd3 : 3'd0);
            end
        end else begin : g_floor
            always_comb begin
                q_exact   = {a[ARG_WIDTH-1], a[ARG_WIDTH-1:2]};
                rem_exact = {1'b0, a[1:0]};
            end
        end
    endgenerate

    pipe_slice #(.WIDTH(S1_WIDTH)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (arg_vld && !rst),
        .in_rdy   (s1_in_rdy),
        .in_data  ({q_exact, rem_exact}),
        .out_vld  (s1_vld),
        .out_rdy  (s2_in_rdy),
        .out_data (s1_data)
    );

    assign arg_rdy = s1_in_rdy && !rst;
    assign s1_q    = s1_data[S1_WIDTH-1:REM_WIDTH];
    assign s1_rem  = s1_data[REM_WIDTH-1:0];

    generate
        if (RES_WIDTH >= Q_WIDTH) begin : g_widen
            assign res_next = RES_WIDTH'(s1_q);
            assign ovf_next = 1'b0;
        end else begin : g_sat
            always_comb begin
                ovf_next = 1'b0;
                res_next = RES_WIDTH'(sat_narrow(SAT_WIDTH'(s1_q), RES_WIDTH, ovf_next));
            end
        end
    endgenerate

    pipe_slice #(.WIDTH(S2_WIDTH)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (s1_vld),
        .in_rdy   (s2_in_rdy),
        .in_data  ({res_next, ovf_next, s1_rem}),
        .out_vld  (res_vld),
        .out_rdy  (res_rdy),
        .out_data (s2_data)
    );

    assign res      = s2_data[S2_WIDTH-1:REM_WIDTH+1];
    assign overflow = s2_data[REM_WIDTH];
    assign rem      = s2_data[REM_WIDTH-1:0];

endmodule

// File: tb/tb_sr_2_pipe.sv
// Bench for sr_2_pipe: four configurations (8/8 and 8/4 bits, floor and trunc)
// share one stimulus stream; directed table, hand sequences, random scoreboard.
module tb_sr_2_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       arg_vld;
    logic       res_rdy;
    logic [7:0] a;

    logic       rdy_f8, rdy_t8, rdy_f4, rdy_t4;
    logic       vld_f8, vld_t8, vld_f4, vld_t4;
    logic [7:0] res_f8, res_t8;
    logic [3:0] res_f4, res_t4;
    logic [2:0] rem_f8, rem_t8, rem_f4, rem_t4;
    logic       ov_f8, ov_t8, ov_f4, ov_t4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int res_f8; int rem_f8;
        int res_t8; int rem_t8;
        int res_f4; int ov_f4; int rem_f4;
        int res_t4; int ov_t4; int rem_t4;
    } vec_t;

    localparam int N_VEC  = 15;
    localparam int N_RAND = 10000;

    vec_t vecs[N_VEC];
    vec_t exp_q[$];
    logic mon_en  = 1'b0;
    logic in_fire = 1'b0;
    int   n_acc   = 0;

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    sr_2_pipe #(.ARG_WIDTH(8), .RES_WIDTH(8), .ROUND_MODE(sr_pkg::RM_FLOOR)) u_f8 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(rdy_f8), .a(a),
        .res_vld(vld_f8), .res_rdy(res_rdy), .res(res_f8), .rem(rem_f8), .overflow(ov_f8));
    sr_2_pipe #(.ARG_WIDTH(8), .RES_WIDTH(8), .ROUND_MODE(sr_pkg::RM_TRUNC)) u_t8 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(rdy_t8), .a(a),
        .res_vld(vld_t8), .res_rdy(res_rdy), .res(res_t8), .rem(rem_t8), .overflow(ov_t8));
    sr_2_pipe #(.ARG_WIDTH(8), .RES_WIDTH(4), .ROUND_MODE(sr_pkg::RM_FLOOR)) u_f4 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(rdy_f4), .a(a),
        .res_vld(vld_f4), .res_rdy(res_rdy), .res(res_f4), .rem(rem_f4), .overflow(ov_f4));
    sr_2_pipe #(.ARG_WIDTH(8), .RES_WIDTH(4), .ROUND_MODE(sr_pkg::RM_TRUNC)) u_t4 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(rdy_t4), .a(a),
        .res_vld(vld_t4), .res_rdy(res_rdy), .res(res_t4), .rem(rem_t4), .overflow(ov_t4));

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vld(input string tag, input int exp);
        check({tag, " vld_f8"}, int'(vld_f8), exp);
        check({tag, " vld_t8"}, int'(vld_t8), exp);
        check({tag, " vld_f4"}, int'(vld_f4), exp);
        check({tag, " vld_t4"}, int'(vld_t4), exp);
    endtask

    task automatic check_rdy(input string tag, input int exp);
        check({tag, " rdy_f8"}, int'(rdy_f8), exp);
        check({tag, " rdy_t4"}, int'(rdy_t4), exp);
    endtask

    task automatic check_out(input string tag, input vec_t e);
        check({tag, " res_f8"}, int'($signed(res_f8)), e.res_f8);
        check({tag, " rem_f8"}, int'($signed(rem_f8)), e.rem_f8);
        check({tag, " ov_f8"},  int'(ov_f8), 0);
        check({tag, " res_t8"}, int'($signed(res_t8)), e.res_t8);
        check({tag, " rem_t8"}, int'($signed(rem_t8)), e.rem_t8);
        check({tag, " ov_t8"},  int'(ov_t8), 0);
        check({tag, " res_f4"}, int'($signed(res_f4)), e.res_f4);
        check({tag, " ov_f4"},  int'(ov_f4), e.ov_f4);
        check({tag, " rem_f4"}, int'($signed(rem_f4)), e.rem_f4);
        check({tag, " res_t4"}, int'($signed(res_t4)), e.res_t4);
        check({tag, " ov_t4"},  int'(ov_t4), e.ov_t4);
        check({tag, " rem_t4"}, int'($signed(rem_t4)), e.rem_t4);
    endtask

    task automatic check_idle(input string tag);
        check_vld(tag, 0);
        check({tag, " res_f8"}, int'(res_f8), 0);
        check({tag, " rem_f8"}, int'(rem_f8), 0);
        check({tag, " res_t4"}, int'(res_t4), 0);
        check({tag, " ov_f4"},  int'(ov_f4), 0);
    endtask

    function automatic int clamp4(input int q);
        if (q > 7)  return 7;
        if (q < -8) return -8;
        return q;
    endfunction

    // Reference built from integer division, not from shifts.
    function automatic vec_t model(input int av);
        vec_t m;
        int qt, rt, qf, rf;
        qt = av / 4;
        rt = av % 4;
        qf = (rt < 0) ? qt - 1 : qt;
        rf = av - 4 * qf;
        m.a      = av;
        m.res_f8 = qf;  m.rem_f8 = rf;
        m.res_t8 = qt;  m.rem_t8 = rt;
        m.res_f4 = clamp4(qf); m.ov_f4 = int'(qf > 7 || qf < -8); m.rem_f4 = rf;
        m.res_t4 = clamp4(qt); m.ov_t4 = int'(qt > 7 || qt < -8); m.rem_t4 = rt;
        return m;
    endfunction

    // ---------------- scoreboard monitor (random phase) ----------------
    always @(negedge clk) begin
        vec_t e;
        if (mon_en && !rst) begin
            in_fire = arg_vld && rdy_f8;
            check("rand rdy agree", int'(rdy_t8 && rdy_f4 && rdy_t4), int'(rdy_f8));
            if (vld_f8 && res_rdy) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_vld("rand", 1);
                    check_out("rand", e);
                    check("rand 4q+r", 4 * int'($signed(res_f8)) + int'($signed(rem_f8)), e.a);
                    check("rand 4q+r trunc", 4 * int'($signed(res_t8)) + int'($signed(rem_t8)), e.a);
                end
            end
            if (in_fire) begin
                exp_q.push_back(model(int'($signed(a))));
                n_acc++;
            end
        end else begin
            in_fire = 1'b0;
        end
    end

    // ---------------- main test ----------------
    initial begin
        int cyc;
        int bp_exp[3];

        vecs = '{
            '{  13,   3, 1,   3,  1,   3, 0, 1,   3, 0,  1},
            '{ -13,  -4, 3,  -3, -1,  -4, 0, 3,  -3, 0, -1},
            '{-128, -32, 0, -32,  0,  -8, 1, 0,  -8, 1,  0},
            '{ -12,  -3, 0,  -3,  0,  -3, 0, 0,  -3, 0,  0},
            '{  40,  10, 0,  10,  0,   7, 1, 0,   7, 1,  0},
            '{ -40, -10, 0, -10,  0,  -8, 1, 0,  -8, 1,  0},
            '{ -33,  -9, 3,  -8, -1,  -8, 1, 3,  -8, 0, -1},
            '{  28,   7, 0,   7,  0,   7, 0, 0,   7, 0,  0},
            '{ 127,  31, 3,  31,  3,   7, 1, 3,   7, 1,  3},
            '{  -1,  -1, 3,   0, -1,  -1, 0, 3,   0, 0, -1},
            '{   0,   0, 0,   0,  0,   0, 0, 0,   0, 0,  0},
            '{ -29,  -8, 3,  -7, -1,  -8, 0, 3,  -7, 0, -1},
            '{  31,   7, 3,   7,  3,   7, 0, 3,   7, 0,  3},
            '{  32,   8, 0,   8,  0,   7, 1, 0,   7, 1,  0},
            '{ -32,  -8, 0,  -8,  0,  -8, 0, 0,  -8, 0,  0}
        };

        // Reset with a valid operand offered; it must be ignored.
        rst = 1'b1; arg_vld = 1'b1; a = 8'd55; res_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check_rdy("reset", 0);
        @(posedge clk); #1;
        rst = 1'b0; arg_vld = 1'b0;
        @(negedge clk);
        check_idle("post reset 0");
        check_rdy("post reset", 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_idle("post reset 1");
        @(posedge clk); #1;

        // Directed table, continuous flow with res_rdy high: 2-cycle latency.
        for (int i = 0; i < N_VEC + 2; i++) begin
            if (i < N_VEC) begin
                arg_vld = 1'b1;
                a = 8'(vecs[i].a);
            end else begin
                arg_vld = 1'b0;
            end
            @(negedge clk);
            check_rdy($sformatf("vec cyc%0d", i), 1);
            if (i >= 2) begin
                check_vld($sformatf("vec%0d", i - 2), 1);
                check_out($sformatf("vec%0d a=%0d", i - 2, vecs[i - 2].a), vecs[i - 2]);
            end else begin
                check_vld($sformatf("latency cyc%0d", i), 0);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_vld("table drained", 0);
        @(posedge clk); #1;

        // Backpressure: two items fill the pipe, then arg_rdy drops.
        res_rdy = 1'b0; arg_vld = 1'b1; a = 8'd4;
        @(negedge clk); check_rdy("bp accept0", 1);
        @(posedge clk); #1; a = 8'd8;
        @(negedge clk); check_rdy("bp accept1", 1);
        @(posedge clk); #1; a = 8'd12;
        @(negedge clk);
        check_rdy("bp full", 0);
        check_vld("bp full", 1);
        check("bp full res", int'($signed(res_f8)), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_rdy("bp stall", 0);
        check_vld("bp stall", 1);
        check("bp stall res_f8", int'($signed(res_f8)), 1);
        check("bp stall res_t4", int'($signed(res_t4)), 1);
        check("bp stall rem", int'(rem_f8), 0);
        @(posedge clk); #1; res_rdy = 1'b1;
        @(negedge clk);
        check_rdy("bp release", 1);
        check("bp out0", int'($signed(res_f8)), 1);
        @(posedge clk); #1; a = 8'd16;
        bp_exp = '{2, 3, 4};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_vld($sformatf("bp out%0d", k + 1), 1);
            check($sformatf("bp out%0d res_f8", k + 1), int'($signed(res_f8)), bp_exp[k]);
            check($sformatf("bp out%0d res_t8", k + 1), int'($signed(res_t8)), bp_exp[k]);
            @(posedge clk); #1;
            arg_vld = 1'b0;
        end
        @(negedge clk);
        check_vld("bp drained", 0);
        @(posedge clk); #1;

        // Reset mid-flight flushes both stages.
        res_rdy = 1'b0; arg_vld = 1'b1; a = 8'd20;
        @(posedge clk); #1; a = 8'd24;
        @(posedge clk); #1; rst = 1'b1; a = 8'd99;
        @(negedge clk);
        check_rdy("mid rst", 0);
        @(posedge clk); #1;
        rst = 1'b0; res_rdy = 1'b1; a = 8'(-20);
        @(negedge clk);
        check_idle("after mid rst");
        check_rdy("after mid rst", 1);
        @(posedge clk); #1; arg_vld = 1'b0;
        @(negedge clk);
        check_vld("rst recover cyc1", 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_vld("rst recover cyc2", 1);
        check_out("rst recover", model(-20));
        @(posedge clk); #1;

        // Random traffic with random stalls on both sides.
        mon_en = 1'b1;
        cyc = 0;
        while (n_acc < N_RAND && cyc < 60000) begin
            @(posedge clk); #1;
            if (!arg_vld || in_fire) begin
                arg_vld = ($urandom_range(0, 3) != 0) && (n_acc < N_RAND);
                a = 8'($urandom_range(0, 255));
            end
            res_rdy = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("rand accept budget", int'(n_acc >= N_RAND), 1);
        @(posedge clk); #1;
        arg_vld = 1'b0; res_rdy = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rand drain queue", exp_q.size(), 0);
        @(negedge clk);
        check_vld("rand idle", 0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
